// File: rtl/alu_operand_sequencer_if.sv
// alu_operand_sequencer_if: instruction handshake, operand-select, ALU and writeback bus.
// With SEQ_TIMEOUT_EN defined it also carries the sticky err flag.
interface alu_operand_sequencer_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        hold;
    logic [1:0]  sourcex;
    logic [3:0]  arg_a;
    logic [3:0]  arg_b;
    logic [3:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
`ifdef SEQ_TIMEOUT_EN
    logic        err;
`endif
    modport master (
        output instr, instr_valid, hold, alu_done, alu_result,
        input  instr_ready, sourcex, arg_a, arg_b, alu_op, alu_start,
               wr_en, wr_addr, wr_data, busy
`ifdef SEQ_TIMEOUT_EN
        , err
`endif
    );
    modport slave (
        input  instr, instr_valid, hold, alu_done, alu_result,
        output instr_ready, sourcex, arg_a, arg_b, alu_op, alu_start,
               wr_en, wr_addr, wr_data, busy
`ifdef SEQ_TIMEOUT_EN
        , err
`endif
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: latches one instruction, waits RF_LAT for operands, starts the ALU, writes back.
// Optional SEQ_TIMEOUT_EN aborts a WAIT lasting TIMEOUT cycles and sets sticky err.
module alu_operand_sequencer #(
    parameter int RF_LAT  = 1,
    parameter int TIMEOUT = 64
) (
    input logic                    clk,
    input logic                    reset_n,
    alu_operand_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WAIT, WB} state_t;
    state_t     state;
    logic [2:0] lat_cnt;
    logic       wb_en;
    logic       unused_rsvd;
`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] tcnt;
`endif
    if (RF_LAT < 1 || RF_LAT > 7 || TIMEOUT < 1) begin : g_bad_param
        $error("alu_operand_sequencer: RF_LAT must be 1..7 and TIMEOUT >= 1");
    end
    assign unused_rsvd     = bus.instr[15];
    assign bus.instr_ready = state == IDLE && !bus.hold;
    assign bus.busy        = state != IDLE;
    // the write strobe only fires on the WB exit cycle, so a held WB writes once
    assign bus.wr_en       = state == WB && wb_en && !bus.hold;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            wb_en         <= 1'b0;
            bus.sourcex   <= '0;
            bus.arg_a     <= '0;
            bus.arg_b     <= '0;
            bus.alu_op    <= '0;
            bus.alu_start <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
`ifdef SEQ_TIMEOUT_EN
            tcnt          <= '0;
            bus.err       <= 1'b0;
`endif
        end else begin
            bus.alu_start <= 1'b0;
            case (state)
                IDLE: if (bus.instr_valid && !bus.hold) begin
                    wb_en       <= bus.instr[14];
                    bus.alu_op  <= bus.instr[13:10];
                    bus.sourcex <= bus.instr[9:8];
                    bus.arg_a   <= bus.instr[7:4];
                    bus.arg_b   <= bus.instr[3:0];
                    bus.wr_addr <= bus.instr[9] ? 4'd8 : bus.instr[7:4];
                    lat_cnt     <= 3'(RF_LAT - 1);
                    state       <= READ;
                end
                READ: if (!bus.hold) begin
                    if (lat_cnt == 3'd0) begin
                        state         <= EXEC;
                        bus.alu_start <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                EXEC: begin
                    state <= WAIT;
`ifdef SEQ_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                WAIT: begin
                    if (bus.alu_done) begin
                        bus.wr_data <= bus.alu_result;
                        state       <= WB;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT - 1)) begin
                        bus.err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                WB: if (!bus.hold) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed checks of handshake, latency, hold, reset and optional timeout.
// Build with SEQ_TIMEOUT_EN defined to exercise the timeout scenario.
module tb_alu_operand_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    alu_operand_sequencer_if b1 ();
    alu_operand_sequencer_if b2 ();
    alu_operand_sequencer #(.RF_LAT(1), .TIMEOUT(8)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
    alu_operand_sequencer #(.RF_LAT(2), .TIMEOUT(8)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({b1.busy, b1.instr_ready, b1.alu_start, b1.wr_en} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_status: got %b want 0100", {b1.busy, b1.instr_ready, b1.alu_start, b1.wr_en});
        end
        n_checks++;
        if ({b1.sourcex, b1.arg_a, b1.arg_b, b1.alu_op, b1.wr_addr, b1.wr_data} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h want 0", {b1.sourcex, b1.arg_a, b1.arg_b, b1.alu_op, b1.wr_addr, b1.wr_data});
        end
        step();
        reset_n = 1'b1;
        b1.hold = 1'b1;
        b1.instr_valid = 1'b1;
        b1.instr = 16'h4123;
        @(negedge clk);
        n_checks++;
        if (b1.instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle_ready: got %b want 0", b1.instr_ready);
        end
        step();
        b1.hold = 1'b0;
        b1.instr_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({b1.busy, b1.instr_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_idle_noaccept: got %b want 01", {b1.busy, b1.instr_ready});
        end
    endtask

    task automatic test_instr(input string name, input logic [15:0] ins, input logic [15:0] res,
                              input logic [13:0] exp_ops, input logic [3:0] exp_addr, input logic exp_wr);
        logic [3:0] exp_s [6];
        exp_s = '{4'b0100, 4'b1000, 4'b1010, 4'b1000, {3'b100, exp_wr}, 4'b0100};
        for (int c = 0; c < 6; c++) begin
            step();
            b1.instr_valid = (c == 0);
            b1.instr = (c == 0) ? ins : ~ins;
            b1.alu_done = (c == 3);
            b1.alu_result = (c == 3) ? res : 16'h0;
            @(negedge clk);
            n_checks++;
            if ({b1.busy, b1.instr_ready, b1.alu_start, b1.wr_en} !== exp_s[c]) begin
                n_fail++;
                $display("FAIL %s_status c%0d: got %b want %b", name, c,
                         {b1.busy, b1.instr_ready, b1.alu_start, b1.wr_en}, exp_s[c]);
            end
            if (c >= 1 && c <= 4) begin
                n_checks++;
                if ({b1.sourcex, b1.arg_a, b1.arg_b, b1.alu_op} !== exp_ops) begin
                    n_fail++;
                    $display("FAIL %s_operands c%0d: got %h want %h", name, c,
                             {b1.sourcex, b1.arg_a, b1.arg_b, b1.alu_op}, exp_ops);
                end
            end
            if (c == 4) begin
                n_checks++;
                if ({b1.wr_addr, b1.wr_data} !== {exp_addr, res}) begin
                    n_fail++;
                    $display("FAIL %s_wb: got %h want %h", name, {b1.wr_addr, b1.wr_data}, {exp_addr, res});
                end
            end
        end
    endtask

    task automatic test_hold_read();
        logic [3:0] exp_s [12];
        exp_s = '{4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                  4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b0100};
        for (int c = 0; c < 12; c++) begin
            step();
            b2.instr_valid = (c == 0);
            b2.instr = (c == 0) ? 16'h4123 : 16'h0000;
            b2.hold = (c >= 1 && c <= 3) || c == 8 || c == 9;
            b2.alu_done = (c == 7);
            b2.alu_result = (c == 7) ? 16'h1234 : 16'h0;
            @(negedge clk);
            n_checks++;
            if ({b2.busy, b2.instr_ready, b2.alu_start, b2.wr_en} !== exp_s[c]) begin
                n_fail++;
                $display("FAIL hold_status c%0d: got %b want %b", c,
                         {b2.busy, b2.instr_ready, b2.alu_start, b2.wr_en}, exp_s[c]);
            end
            if (c == 10) begin
                n_checks++;
                if ({b2.wr_addr, b2.wr_data} !== 20'h21234) begin
                    n_fail++;
                    $display("FAIL hold_wb: got %h want 21234", {b2.wr_addr, b2.wr_data});
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        for (int c = 0; c < 6; c++) begin
            step();
            b1.instr_valid = (c == 0);
            b1.instr = 16'h42A5;
            b1.alu_done = (c == 4);
            b1.alu_result = (c == 4) ? 16'hDEAD : 16'h0;
            if (c == 3) reset_n = 1'b0;
            if (c == 4) reset_n = 1'b1;
            @(negedge clk);
            if (c >= 3) begin
                n_checks++;
                if ({b1.busy, b1.instr_ready, b1.alu_start, b1.wr_en} !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL rstwait_status c%0d: got %b want 0100", c,
                             {b1.busy, b1.instr_ready, b1.alu_start, b1.wr_en});
                end
                n_checks++;
                if ({b1.sourcex, b1.arg_a, b1.arg_b, b1.alu_op, b1.wr_addr, b1.wr_data} !== 34'h0) begin
                    n_fail++;
                    $display("FAIL rstwait_regs c%0d: got %h want 0", c,
                             {b1.sourcex, b1.arg_a, b1.arg_b, b1.alu_op, b1.wr_addr, b1.wr_data});
                end
            end
        end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        for (int c = 0; c < 15; c++) begin
            step();
            b1.instr_valid = (c == 0);
            b1.instr = 16'h4123;
            b1.alu_done = 1'b0;
            if (c == 14) reset_n = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({b1.busy, b1.instr_ready, b1.alu_start, b1.wr_en, b1.err} !==
                (c == 0 ? 5'b01000 : c == 2 ? 5'b10100 : c <= 10 ? 5'b10000 : c <= 13 ? 5'b01001 : 5'b01000)) begin
                n_fail++;
                $display("FAIL timeout c%0d: got %b", c, {b1.busy, b1.instr_ready, b1.alu_start, b1.wr_en, b1.err});
            end
        end
        step();
        reset_n = 1'b1;
    endtask
`endif

    initial begin
        b1.instr = '0; b1.instr_valid = 1'b0; b1.hold = 1'b0; b1.alu_done = 1'b0; b1.alu_result = '0;
        b2.instr = '0; b2.instr_valid = 1'b0; b2.hold = 1'b0; b2.alu_done = 1'b0; b2.alu_result = '0;
        test_reset();
        test_instr("basic", 16'h4123, 16'hBEEF, {2'b01, 4'h2, 4'h3, 4'h0}, 4'd2, 1'b1);
        test_instr("src10", 16'h42A5, 16'h5A5A, {2'b10, 4'hA, 4'h5, 4'h0}, 4'd8, 1'b1);
        test_instr("nowb", 16'h0113, 16'h7777, {2'b01, 4'h1, 4'h3, 4'h0}, 4'd1, 1'b0);
        test_instr("rsvd_op", 16'hFC5A, 16'h8001, {2'b00, 4'h5, 4'hA, 4'hF}, 4'd5, 1'b1);
        test_hold_read();
        test_reset_in_wait();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
